// File: rtl/complex_mag_stream_isqrt_43ns_22ns.sv
// complex_mag_stream_isqrt_43ns_22ns: iterative restoring square root, one root bit per ce-cycle,
// valid/ready on both sides; returns floor(sqrt(din)) and din - root*root.
module complex_mag_stream_isqrt_43ns_22ns #(
    parameter int DIN_WIDTH  = 43,
    parameter int DOUT_WIDTH = 22,
    parameter int REM_WIDTH  = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [REM_WIDTH-1:0]  dout_rem,
    output logic                  dout_valid,
    input  logic                  dout_ready
);
    localparam int RW = 2 * DOUT_WIDTH;
    localparam int CW = $clog2(DOUT_WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]            state;
    logic [RW-1:0]         rad;
    logic [DOUT_WIDTH-1:0] root, root_nx;
    logic [DOUT_WIDTH+1:0] rem, rem_sh, trial, rem_nx;
    logic [CW-1:0]         cnt;
    logic                  ge;

    assign din_ready  = state == IDLE;
    assign dout_valid = state == DONE;

    // Two extra remainder bits absorb the trial subtraction without overflow.
    always_comb begin
        rem_sh  = (rem << 2) | {{DOUT_WIDTH{1'b0}}, rad[RW-1 -: 2]};
        trial   = {root, 2'b01};
        ge      = rem_sh >= trial;
        rem_nx  = ge ? rem_sh - trial : rem_sh;
        root_nx = {root[DOUT_WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rad      <= '0;
            root     <= '0;
            rem      <= '0;
            cnt      <= '0;
            dout     <= '0;
            dout_rem <= '0;
        end else if (ce) begin
            if (state == IDLE && din_valid) begin
                state <= CALC;
                rad   <= {{(RW-DIN_WIDTH){1'b0}}, din};
                root  <= '0;
                rem   <= '0;
                cnt   <= CW'(DOUT_WIDTH - 1);
            end else if (state == CALC) begin
                rad  <= rad << 2;
                root <= root_nx;
                rem  <= rem_nx;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    state    <= DONE;
                    dout     <= root_nx;
                    dout_rem <= rem_nx[REM_WIDTH-1:0];
                end
            end else if (state == DONE && dout_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/complex_mag_stream_isqrt_43ns_22ns.md
Name: complex_mag_stream_isqrt_43ns_22ns

Overview:
- Downstream stage of the 43-bit unsigned product/sum-of-squares datapath in complex_mag_stream.
- Takes a 43-bit unsigned magnitude-squared word and returns floor(sqrt(x)) plus the remainder.
- Iterative restoring digit-by-digit square root, one root bit per cycle.
- valid/ready handshake on both sides, so it sits between the multiply pipeline and the output stream register.

Parameters:
- DIN_WIDTH, 43, input width (unsigned).
- DOUT_WIDTH, 22, root width; must equal ceil(DIN_WIDTH/2).
- REM_WIDTH, 23, remainder width; equals DOUT_WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ce  input  1  clock enable; when low, all state and outputs hold.
- din  input  DIN_WIDTH  radicand, unsigned.
- din_valid  input  1  radicand present.
- din_ready  output  1  block can accept a radicand.
- dout  output  DOUT_WIDTH  floor(sqrt(din)).
- dout_rem  output  REM_WIDTH  din - dout*dout.
- dout_valid  output  1  result present.
- dout_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, any state): state=IDLE, din_ready=1, dout_valid=0, dout=0, dout_rem=0, iteration counter=0, internal radicand/remainder registers=0.
- All transitions and register updates occur only on a rising clk with ce=1. With ce=0, every register holds, including the counter. Handshake outputs keep their values.
- FSM states are IDLE, CALC and DONE.
  - IDLE: din_ready=1, dout_valid=0. On din_valid=1, capture din zero-extended to 2*DOUT_WIDTH bits (44). Clear the partial root and remainder, set counter=DOUT_WIDTH-1, and go to CALC.
  - CALC: din_ready=0. Each cycle:
    - Shift the top two radicand bits into the remainder: rem = (rem<<2) | next pair.
    - Compute trial = (root<<2)|1.
    - If rem >= trial: rem -= trial and root = (root<<1)|1. Otherwise root = root<<1.
    - When counter==0, go to DONE and latch dout and dout_rem in the same edge. Otherwise decrement the counter.
  - DONE: dout_valid=1, din_ready=0. On dout_ready=1, go to IDLE and drop dout_valid. dout and dout_rem hold their last values; they are not cleared.
- Latency: with the accept edge as edge 0, dout_valid rises after edge DOUT_WIDTH (22 edges of ce=1).
- Throughput: at most one result per DOUT_WIDTH+2 = 24 ce-cycles. There is no accept/return overlap.
- din is sampled only on the accept edge; changes to din during CALC/DONE are ignored.
- din_valid during CALC/DONE is not accepted. The upstream holds it, per the valid/ready rule.
- Backpressure: dout_ready=0 in DONE holds dout, dout_rem and dout_valid indefinitely.
- Internal remainder is DOUT_WIDTH+2 bits to hold the trial subtraction without overflow. The final remainder always fits REM_WIDTH (<= 2*root).
- Reset asserted mid-CALC or in DONE aborts immediately. The pending result is lost and no dout_valid pulse is produced.
- Input 0 is legal: the result is root 0, rem 0 with the normal latency.

Test Plan:
- din=0 accepted -> dout_valid after 22 cycles, dout=0, dout_rem=0; din_ready returns 1 after the dout_ready handshake.
- din=99, then din=1000000 back-to-back, dout_ready tied 1 -> 9/rem 18, then 1000/rem 0. Second accept no earlier than 24 cycles after the first.
- din=2^43-1 (8796093022207) -> dout=2965820, dout_rem=4749807.
- din=16, dout_ready held 0 for 10 cycles after dout_valid -> dout=4, rem=0 stable throughout; din_ready=0 until release. din_valid with din=25 during the stall is not accepted.
- ce low for 5 cycles mid-CALC on din=2^42 -> dout=2097152, rem=0, dout_valid delayed by exactly 5 cycles.
- reset pulsed at iteration 10 of din=12345 -> outputs return to reset values asynchronously. The next din=144 yields 12/rem 0 with the full 22-cycle latency.
